soduku_board_loader: RTL
========================

// Module: soduku_board_loader
// PURPOSE
//  Writer side of the solver's board_in bus: accepts puzzle givens one cell per handshake and
//  assembles the 324-bit packed BCD board. Checks each digit for range and for row/col/square
//  duplicates. After the 81st cell, pulses the solver's asynchronous reset so the solver latches the new board.
//  Sits between the input source (keypad/UART cell stream) and soduku_solver.
// PARAMETERS
//  GRID_SIZE   9   cells per row/col; fixed at 9 (3x3 squares), other values unsupported
//  CELL_W      4   bits per BCD cell
//  KICK_CYCLES 2   cycles solver_reset_out is held high after a complete load (>=1)
// PORTS
//  clk_in            in   1    clock
//  reset_in          in   1    asynchronous, active-high reset
//  load_start_in     in   1    pulse: begin (or restart) a board load
//  cell_valid_in     in   1    cell_data_in valid
//  cell_data_in      in   4    BCD digit 0..9; 0 = blank cell
//  cell_ready_out    out  1    loader accepts a cell this cycle
//  cell_index_out    out  7    index 0..80 of next cell to be written (row*9+col)
//  board_out         out  324  packed board to solver board_in
//  solver_reset_out  out  1    drives solver reset_in
//  load_busy_out     out  1    high in LOAD or KICK
//  load_done_out     out  1    one-cycle pulse, load complete and solver kicked
//  load_error_out    out  1    sticky: a digit > 9 was received
//  load_conflict_out out  1    sticky: duplicate non-zero given in a row, column or square
// BEHAVIOUR
//  Reset: state=IDLE; board_out=0; cell_index_out=0; all other outputs 0; all masks 0.
//  Packing: cell k=row*9+col occupies board_out[4k+3:4k], row 0 col 0 at bits [3:0].
//  FSM IDLE -> LOAD -> KICK -> IDLE.
//   IDLE: cell_ready_out=0. load_start_in -> LOAD.
//    Same edge: index=0, board_out=0, row/col/square masks=0, error and conflict cleared.
//   LOAD: cell_ready_out=1 (combinational from state).
//    Accept when cell_valid_in & cell_ready_out; one cell/cycle max.
//    board_out updates on the edge of acceptance; index increments on the same edge.
//    digit>9: cell written as 0, load_error_out set, no mask update.
//    digit 1..9: if bit (digit-1) is already set in row_mask[r], col_mask[c] or sq_mask[(r/3)*3+c/3]
//     -> load_conflict_out set. Cell is still written and masks are OR-updated.
//    digit 0: written, masks untouched.
//    Acceptance at index 80 -> KICK. cell_index_out holds 80 (no wrap to 81).
//    load_start_in in LOAD: restart, same clearing as IDLE->LOAD.
//     Takes priority over a same-cycle cell handshake; that cell is dropped.
//   KICK: cell_ready_out=0; solver_reset_out=1 for exactly KICK_CYCLES cycles (registered).
//    Then -> IDLE with load_done_out=1 for one cycle; solver_reset_out returns to 0 that cycle.
//    load_start_in ignored in KICK.
//  board_out is stable throughout KICK, so the solver latches the completed board.
//  board_out holds its value in IDLE until the next load_start_in.
//  load_busy_out = (state != IDLE). Error/conflict flags remain readable after done.
//  reset_in mid-load: immediate return to reset values; no solver kick is issued.
//  Row/col counters kept alongside index (col wraps 8->0 with row++) to avoid divide logic.
// TESTING
//  1 Reset, start, stream 81 cells of a valid puzzle with no gaps in valid -> done 81 cycles after
//    the first handshake + KICK_CYCLES. Then board_out matches the packing; error=conflict=0.
//  2 cell_valid_in toggled 1/0 every cycle -> 81 accepts over 161 cycles;
//    cell_index_out steps only on handshakes; solver_reset_out high exactly 2 cycles.
//  3 Cell 0=5, cell 4=5 (same row) -> load_conflict_out=1 after cell 4.
//    Also: cell 9=7 and cell 10=7 (same square) -> conflict. board_out still holds both 5s and both 7s.
//  4 cell_data_in=4'hC at index 3 -> board_out[15:12]=0, load_error_out=1, load completes normally.
//  5 load_start_in at index 40 with a concurrent handshake -> index=0, board_out=0, flags cleared,
//    dropped cell absent; a full reload then completes.
//  6 reset_in asserted at index 60 -> all outputs 0 asynchronously; solver_reset_out never pulses.
//    load_start_in during KICK -> ignored.

Source files
------------

// File: rtl/soduku_board_loader.sv
`default_nettype none
// ============================================================================
// Module      : soduku_board_loader
// Description : Writer side of the solver board_in bus. Accepts puzzle givens
//               one cell per valid/ready handshake and packs them into the
//               324-bit BCD board. Flags out-of-range digits and duplicate
//               givens per row, column and 3x3 square. After the 81st cell it
//               holds the solver reset high for KICK_CYCLES cycles so the
//               solver latches the finished board.
// Revision    : 1.0 - initial release
// ============================================================================
module soduku_board_loader #(
  parameter int GRID_SIZE   = 9,  // fixed 9x9 grid with 3x3 squares
  parameter int CELL_W      = 4,  // BCD digit width
  parameter int KICK_CYCLES = 2   // solver reset pulse length, >= 1
) (
  input  logic                                  clk_in,
  input  logic                                  reset_in,
  input  logic                                  load_start_in,
  input  logic                                  cell_valid_in,
  input  logic [CELL_W-1:0]                     cell_data_in,
  output logic                                  cell_ready_out,
  output logic [6:0]                            cell_index_out,
  output logic [GRID_SIZE*GRID_SIZE*CELL_W-1:0] board_out,
  output logic                                  solver_reset_out,
  output logic                                  load_busy_out,
  output logic                                  load_done_out,
  output logic                                  load_error_out,
  output logic                                  load_conflict_out
);

  localparam int                    c_CELLS      = GRID_SIZE * GRID_SIZE;
  localparam int                    c_BOARD_W    = c_CELLS * CELL_W;
  localparam logic [6:0]            c_LAST_INDEX = 7'(c_CELLS - 1);
  localparam logic [3:0]            c_LAST_RC    = 4'(GRID_SIZE - 1);
  localparam logic [CELL_W-1:0]     c_MAX_DIGIT  = CELL_W'(9);
  localparam int                    c_KICK_W     = (KICK_CYCLES > 1) ? $clog2(KICK_CYCLES) : 1;
  localparam logic [c_KICK_W-1:0]   c_KICK_LAST  = c_KICK_W'(KICK_CYCLES - 1);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_LOAD = 2'd1;
  localparam logic [1:0] c_ST_KICK = 2'd2;

  // Registered state
  logic [1:0]           r_state;
  logic [6:0]           r_index;
  logic [3:0]           r_row;
  logic [3:0]           r_col;
  logic [c_BOARD_W-1:0] r_board;
  logic [c_KICK_W-1:0]  r_kick_cnt;
  logic                 r_solver_reset;
  logic                 r_done;
  logic                 r_error;
  logic                 r_conflict;
  logic [GRID_SIZE-1:0] r_row_mask [0:GRID_SIZE-1];
  logic [GRID_SIZE-1:0] r_col_mask [0:GRID_SIZE-1];
  logic [GRID_SIZE-1:0] r_sq_mask  [0:GRID_SIZE-1];

  // Combinational decode
  logic                 w_start;
  logic                 w_accept;
  logic                 w_digit_bad;
  logic [CELL_W-1:0]    w_cell;
  logic [GRID_SIZE-1:0] w_digit_bit;
  logic [3:0]           w_sq;
  logic [GRID_SIZE-1:0] w_seen;
  logic                 w_dup;

  // Row or column 0..8 mapped to its band 0..2 without a divider
  function automatic logic [1:0] band_of(input logic [3:0] v);
    if (v < 4'd3)      band_of = 2'd0;
    else if (v < 4'd6) band_of = 2'd1;
    else               band_of = 2'd2;
  endfunction

  // A start is honoured in IDLE and LOAD only; it wins over a same-cycle cell
  assign w_start     = load_start_in && (r_state != c_ST_KICK);
  assign w_accept    = (r_state == c_ST_LOAD) && cell_valid_in && !load_start_in;
  assign w_digit_bad = (cell_data_in > c_MAX_DIGIT);
  assign w_cell      = w_digit_bad ? '0 : cell_data_in;
  assign w_sq        = ({2'b00, band_of(r_row)} * 4'd3) + {2'b00, band_of(r_col)};
  assign w_seen      = r_row_mask[r_row] | r_col_mask[r_col] | r_sq_mask[w_sq];
  assign w_dup       = |(w_seen & w_digit_bit);

  // One-hot of the digit; blanks and out-of-range digits never touch the masks
  always_comb begin
    w_digit_bit = '0;
    if (!w_digit_bad && (cell_data_in != '0)) begin
      w_digit_bit[cell_data_in - CELL_W'(1)] = 1'b1;
    end
  end

  // Main sequencer: IDLE -> LOAD -> KICK -> IDLE, with the registered solver kick
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_state        <= c_ST_IDLE;
      r_kick_cnt     <= '0;
      r_solver_reset <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (load_start_in) begin
            r_state <= c_ST_LOAD;
          end
        end
        c_ST_LOAD: begin
          if (!load_start_in && w_accept && (r_index == c_LAST_INDEX)) begin
            r_state        <= c_ST_KICK;
            r_solver_reset <= 1'b1;
            r_kick_cnt     <= '0;
          end
        end
        c_ST_KICK: begin
          if (r_kick_cnt == c_KICK_LAST) begin
            r_state        <= c_ST_IDLE;
            r_solver_reset <= 1'b0;
            r_done         <= 1'b1;
          end else begin
            r_kick_cnt <= r_kick_cnt + c_KICK_W'(1);
          end
        end
        default: begin
          r_state        <= c_ST_IDLE;
          r_solver_reset <= 1'b0;
        end
      endcase
    end
  end

  // Cell index with row/col counters tracked alongside; index saturates at 80
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_index <= '0;
      r_row   <= '0;
      r_col   <= '0;
    end else if (w_start) begin
      r_index <= '0;
      r_row   <= '0;
      r_col   <= '0;
    end else if (w_accept && (r_index != c_LAST_INDEX)) begin
      r_index <= r_index + 7'd1;
      if (r_col == c_LAST_RC) begin
        r_col <= '0;
        r_row <= r_row + 4'd1;
      end else begin
        r_col <= r_col + 4'd1;
      end
    end
  end

  // Board assembly: each accepted cell lands in its nibble on the acceptance edge
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_board <= '0;
    end else if (w_start) begin
      r_board <= '0;
    end else if (w_accept) begin
      r_board[int'(r_index) * CELL_W +: CELL_W] <= w_cell;
    end
  end

  // Sticky range and duplicate flags, cleared only by a new load or reset
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_error    <= 1'b0;
      r_conflict <= 1'b0;
    end else if (w_start) begin
      r_error    <= 1'b0;
      r_conflict <= 1'b0;
    end else if (w_accept) begin
      if (w_digit_bad) begin
        r_error <= 1'b1;
      end
      if (w_dup) begin
        r_conflict <= 1'b1;
      end
    end
  end

  // Seen-digit masks per row, column and square; duplicates still get OR-ed in
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      for (int i = 0; i < GRID_SIZE; i++) begin
        r_row_mask[i] <= '0;
        r_col_mask[i] <= '0;
        r_sq_mask[i]  <= '0;
      end
    end else if (w_start) begin
      for (int i = 0; i < GRID_SIZE; i++) begin
        r_row_mask[i] <= '0;
        r_col_mask[i] <= '0;
        r_sq_mask[i]  <= '0;
      end
    end else if (w_accept) begin
      r_row_mask[r_row] <= r_row_mask[r_row] | w_digit_bit;
      r_col_mask[r_col] <= r_col_mask[r_col] | w_digit_bit;
      r_sq_mask[w_sq]   <= r_sq_mask[w_sq]   | w_digit_bit;
    end
  end

  assign cell_ready_out    = (r_state == c_ST_LOAD);
  assign load_busy_out     = (r_state != c_ST_IDLE);
  assign cell_index_out    = r_index;
  assign board_out         = r_board;
  assign solver_reset_out  = r_solver_reset;
  assign load_done_out     = r_done;
  assign load_error_out    = r_error;
  assign load_conflict_out = r_conflict;

endmodule
`default_nettype wire
